// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter (AR + R only) sharing one slave read port.
// Round-robin grant, one burst in flight, grant held until the final beat.
module axi_rd_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   // master 0 (icache refill)
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   input  logic [ADDR_WIDTH-1:0] m0_araddr,
   input  logic [ID_WIDTH-1:0]   m0_arid,
   input  logic [7:0]            m0_arlen,
   input  logic [2:0]            m0_arsize,
   input  logic [1:0]            m0_arburst,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic [1:0]            m0_rresp,
   output logic                  m0_rlast,
   // master 1 (LSU / dcache)
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   input  logic [ADDR_WIDTH-1:0] m1_araddr,
   input  logic [ID_WIDTH-1:0]   m1_arid,
   input  logic [7:0]            m1_arlen,
   input  logic [2:0]            m1_arsize,
   input  logic [1:0]            m1_arburst,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [1:0]            m1_rresp,
   output logic                  m1_rlast,
   // slave port
   output logic                  s_arvalid,
   input  logic                  s_arready,
   output logic [ADDR_WIDTH-1:0] s_araddr,
   output logic [ID_WIDTH-1:0]   s_arid,
   output logic [7:0]            s_arlen,
   output logic [2:0]            s_arsize,
   output logic [1:0]            s_arburst,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   input  logic [DATA_WIDTH-1:0] s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rlast,
   // status
   output logic                  busy,
   output logic                  burst_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [ID_WIDTH-1:0]   id;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
   } ar_t;

   state_t state_q, state_d;
   ar_t    ar_q, ar_d;
   logic   grant_q, grant_d;
   logic   rr_last_q, rr_last_d;
   logic   s_arvalid_q, s_arvalid_d;
   logic   [7:0] beat_cnt_q, beat_cnt_d;
   logic   burst_err_q, burst_err_d;

   ar_t  [1:0]                 m_ar;
   logic [1:0]                 m_arvalid, m_arready, m_rready, m_rvalid, m_rlast;
   logic [1:0][DATA_WIDTH-1:0] m_rdata;
   logic [1:0][1:0]            m_rresp;

   logic win, any_req, in_idle, in_data, beat;

   assign m_ar[0]   = {m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst};
   assign m_ar[1]   = {m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst};
   assign m_arvalid = {m1_arvalid, m0_arvalid};
   assign m_rready  = {m1_rready, m0_rready};

   // On a tie the master that did not win last time goes next.
   assign win     = (m_arvalid == 2'b11) ? ~rr_last_q : m_arvalid[1];
   assign any_req = |m_arvalid;
   // arready is combinational, so it is gated by reset to read 0 while held.
   assign in_idle = (state_q == IDLE) & ~reset;
   assign in_data = (state_q == DATA);

   assign s_rready = in_data & m_rready[grant_q];
   assign beat     = s_rvalid & s_rready;

   for (genvar g = 0; g < 2; g++) begin : g_mst
      localparam logic GSEL = 1'(g);
      logic sel;
      assign sel          = in_data & (grant_q == GSEL);
      assign m_arready[g] = in_idle & any_req & (win == GSEL);
      assign m_rvalid[g]  = sel & s_rvalid;
      assign m_rlast[g]   = sel & s_rlast;
      assign m_rdata[g]   = sel ? s_rdata : '0;
      assign m_rresp[g]   = sel ? s_rresp : 2'b00;
   end

   assign m0_arready = m_arready[0];
   assign m1_arready = m_arready[1];
   assign m0_rvalid  = m_rvalid[0];
   assign m1_rvalid  = m_rvalid[1];
   assign m0_rlast   = m_rlast[0];
   assign m1_rlast   = m_rlast[1];
   assign m0_rdata   = m_rdata[0];
   assign m1_rdata   = m_rdata[1];
   assign m0_rresp   = m_rresp[0];
   assign m1_rresp   = m_rresp[1];

   assign s_arvalid = s_arvalid_q;
   assign s_araddr  = ar_q.addr;
   assign s_arid    = ar_q.id;
   assign s_arlen   = ar_q.len;
   assign s_arsize  = ar_q.size;
   assign s_arburst = ar_q.burst;
   assign busy      = (state_q != IDLE);
   assign burst_err = burst_err_q;

   always_comb begin
      state_d     = state_q;
      ar_d        = ar_q;
      grant_d     = grant_q;
      rr_last_d   = rr_last_q;
      s_arvalid_d = s_arvalid_q;
      beat_cnt_d  = beat_cnt_q;
      burst_err_d = burst_err_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               ar_d        = m_ar[win];
               grant_d     = win;
               rr_last_d   = win;
               s_arvalid_d = 1'b1;
               beat_cnt_d  = 8'd0;
               state_d     = ADDR;
            end
         end
         ADDR: begin
            if (s_arready && s_arvalid_q) begin
               s_arvalid_d = 1'b0;
               state_d     = DATA;
            end
         end
         DATA: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               // rlast must coincide exactly with beat number arlen
               if (s_rlast != (beat_cnt_q == ar_q.len)) burst_err_d = 1'b1;
               if (s_rlast) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ar_q        <= '0;
         grant_q     <= 1'b0;
         rr_last_q   <= 1'b1;
         s_arvalid_q <= 1'b0;
         beat_cnt_q  <= 8'd0;
         burst_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ar_q        <= ar_d;
         grant_q     <= grant_d;
         rr_last_q   <= rr_last_d;
         s_arvalid_q <= s_arvalid_d;
         beat_cnt_q  <= beat_cnt_d;
         burst_err_q <= burst_err_d;
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: AR and R beats checked through scoreboard queues.
module tb_axi_rd_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
   logic [31:0] m0_araddr, m0_rdata;
   logic [3:0]  m0_arid;
   logic [7:0]  m0_arlen;
   logic [2:0]  m0_arsize;
   logic [1:0]  m0_arburst, m0_rresp;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
   logic [31:0] m1_araddr, m1_rdata;
   logic [3:0]  m1_arid;
   logic [7:0]  m1_arlen;
   logic [2:0]  m1_arsize;
   logic [1:0]  m1_arburst, m1_rresp;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [31:0] s_araddr, s_rdata;
   logic [3:0]  s_arid;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize;
   logic [1:0]  s_arburst, s_rresp;
   logic        busy, burst_err;

   always #5 clock = ~clock;

   axi_rd_arbiter dut (
      .clock(clock), .reset(reset),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
      .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
      .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
      .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
      .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rlast(s_rlast),
      .busy(busy), .burst_err(burst_err)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [48:0] arq[$];
   logic [35:0] rq[$];
   logic        exp_grant, exp_rr, exp_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic pick(input logic v0, input logic v1, input logic rr);
      if (v0 && v1) return ~rr;
      return v1;
   endfunction

   // Scoreboard side: slave AR handshakes and master R handshakes.
   always @(negedge clock) begin
      if (!reset) begin
         if (s_arvalid && s_arready) begin
            chk("arq_nonempty", 64'(arq.size() != 0), 1);
            if (arq.size() != 0)
               chk("ar_fields", {s_araddr, s_arid, s_arlen, s_arsize, s_arburst}, arq.pop_front());
         end
         if (m0_rvalid && m0_rready) begin
            chk("rq_nonempty_m0", 64'(rq.size() != 0), 1);
            if (rq.size() != 0) chk("beat_m0", {1'b0, m0_rdata, m0_rresp, m0_rlast}, rq.pop_front());
         end
         if (m1_rvalid && m1_rready) begin
            chk("rq_nonempty_m1", 64'(rq.size() != 0), 1);
            if (rq.size() != 0) chk("beat_m1", {1'b1, m1_rdata, m1_rresp, m1_rlast}, rq.pop_front());
         end
      end
   end

   task automatic ar_phase(input logic v0, input logic v1, input logic keep, input int dly);
      logic w;
      m0_arvalid = v0;
      m1_arvalid = v1;
      w = pick(v0, v1, exp_rr);
      @(negedge clock);
      chk("m0_arready", m0_arready, !w);
      chk("m1_arready", m1_arready, w);
      if (w) arq.push_back({m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst});
      else   arq.push_back({m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst});
      exp_grant = w;
      exp_rr    = w;
      @(posedge clock); #1;
      if (!keep) begin
         if (w) m1_arvalid = 1'b0;
         else   m0_arvalid = 1'b0;
      end
      for (int i = 0; i < dly; i++) begin
         @(negedge clock);
         chk("s_arvalid_hold", s_arvalid, 1);
         chk("busy_addr", busy, 1);
         chk("arready_in_addr", {m0_arready, m1_arready}, 0);
         @(posedge clock); #1;
      end
      s_arready = 1'b1;
      @(negedge clock);
      chk("s_arvalid", s_arvalid, 1);
      @(posedge clock); #1;
      s_arready = 1'b0;
   endtask

   task automatic beats(input int n, input int rlast_at, input int st_from, input int st_len);
      int   cyc;
      logic took, stalled, g;
      cyc = 0;
      g   = exp_grant;
      for (int b = 0; b < n; b++) begin
         s_rvalid = 1'b1;
         s_rdata  = $urandom;
         s_rresp  = 2'(b);
         s_rlast  = (b == rlast_at);
         rq.push_back({g, s_rdata, s_rresp, s_rlast});
         took = 1'b0;
         while (!took) begin
            stalled = (cyc >= st_from) && (cyc < st_from + st_len);
            if (g) begin m1_rready = !stalled; m0_rready = 1'b1; end
            else   begin m0_rready = !stalled; m1_rready = 1'b1; end
            @(negedge clock);
            took = s_rready;
            chk("s_rready_track", s_rready, g ? m1_rready : m0_rready);
            chk("ng_rvalid", g ? {m0_rvalid, m0_rlast} : {m1_rvalid, m1_rlast}, 0);
            chk("arready_in_data", {m0_arready, m1_arready}, 0);
            @(posedge clock); #1;
            cyc++;
            if (cyc > 200) begin
               chk("beat_timeout", took, 1);
               took = 1'b1;
            end
         end
      end
      s_rvalid  = 1'b0;
      s_rlast   = 1'b0;
      m0_rready = 1'b1;
      m1_rready = 1'b1;
   endtask

   task automatic idle_chk(input string tag);
      @(negedge clock);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, burst_err, exp_err);
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      #1 reset = 1'b1;
      #1;
      chk("rst_s_arvalid", s_arvalid, 0);
      chk("rst_s_rready", s_rready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", burst_err, 0);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}, 0);
      exp_rr    = 1'b1;
      exp_err   = 1'b0;
      s_rvalid  = 1'b0;
      s_rlast   = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      {m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst} = '0;
      {m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst} = '0;
      s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0;
      m0_rready = 1; m1_rready = 1;
      // Requests held during reset must not be acknowledged.
      m0_arvalid = 1; m1_arvalid = 1;
      #1 reset = 1'b1;
      #1;
      chk("rst_arready", {m0_arready, m1_arready}, 0);
      chk("rst_s_arvalid", s_arvalid, 0);
      chk("rst_s_rready", s_rready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", burst_err, 0);
      chk("rst_s_ar", {s_araddr, s_arlen, s_arid}, 0);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}, 0);
      m0_arvalid = 0; m1_arvalid = 0;
      exp_rr = 1'b1; exp_err = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;

      // Single M0 burst of 4 beats, slave accepts AR after 2 cycles.
      m0_araddr = 32'h3000_0010; m0_arid = 4'h5; m0_arlen = 8'd3; m0_arsize = 3'd2; m0_arburst = 2'd1;
      ar_phase(1, 0, 0, 2);
      chk("t1_s_araddr", s_araddr, 32'h3000_0010);
      chk("t1_s_arlen", s_arlen, 3);
      beats(4, 3, 0, 0);
      idle_chk("t1");

      // Tie right after reset: M0, M1, M0 with both held valid.
      do_reset();
      m0_araddr = 32'h0000_1000; m0_arid = 4'h1; m0_arlen = 8'd0; m0_arsize = 3'd2; m0_arburst = 2'd1;
      m1_araddr = 32'h8000_2000; m1_arid = 4'h9; m1_arlen = 8'd0; m1_arsize = 3'd3; m1_arburst = 2'd0;
      ar_phase(1, 1, 1, 0);
      chk("t2_grant1", exp_grant, 0);
      beats(1, 0, 0, 0);
      ar_phase(1, 1, 1, 1);
      chk("t2_grant2", exp_grant, 1);
      beats(1, 0, 0, 0);
      ar_phase(1, 1, 0, 0);
      chk("t2_grant3", exp_grant, 0);
      m1_arvalid = 0;
      beats(1, 0, 0, 0);
      idle_chk("t2");

      // M1 8-beat burst with rready low for 3 cycles mid-burst.
      m1_araddr = 32'h4000_0100; m1_arid = 4'h3; m1_arlen = 8'd7; m1_arsize = 3'd2; m1_arburst = 2'd1;
      ar_phase(0, 1, 0, 0);
      beats(8, 7, 3, 3);
      idle_chk("t3");

      // Early rlast on beat 2 of a 4-beat burst, then a clean burst.
      m0_araddr = 32'h3000_0200; m0_arid = 4'h2; m0_arlen = 8'd3;
      ar_phase(1, 0, 0, 1);
      beats(2, 1, 0, 0);
      exp_err = 1'b1;
      idle_chk("t4_early");
      m1_araddr = 32'h4000_0300; m1_arid = 4'h4; m1_arlen = 8'd1;
      ar_phase(0, 1, 0, 0);
      beats(2, 1, 0, 0);
      idle_chk("t4_clean");

      // Reset while a beat is being presented in DATA.
      m0_araddr = 32'h3000_0400; m0_arid = 4'h6; m0_arlen = 8'd3;
      ar_phase(1, 0, 0, 0);
      beats(2, -1, 0, 0);
      s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rlast = 1'b0;
      do_reset();
      m1_araddr = 32'h4000_0500; m1_arid = 4'hA; m1_arlen = 8'd0;
      ar_phase(0, 1, 0, 0);
      chk("t5_grant", exp_grant, 1);
      beats(1, 0, 0, 0);
      idle_chk("t5");

      chk("rq_drained", rq.size(), 0);
      chk("arq_drained", arq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
